// File: rtl/rr_arbiter_enc4.sv
// ---------------------------------------------------------------------------
// rr_arbiter_enc4
//
// Four-requester round-robin arbiter in front of one shared resource. A
// registered one-hot grant and its 2-bit binary index are issued one cycle
// after arbitration. The index drives the resource's select lines. A grant is
// held until its owner drops the request. After every release there is one
// IDLE cycle before the next grant.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   Defined   - an 8-bit hold counter force-releases a grant after MAX_HOLD
//               cycles. timeout pulses for one cycle, in the same cycle that
//               gnt drops.
//   Undefined - grants are held indefinitely and timeout is tied low.
//
// Parameters:
//   NREQ      number of requesters; only 4 is supported
//   MAX_HOLD  longest a grant may be held, in cycles (1..255);
//             used only with ARB_TIMEOUT_EN
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (deassertion synchronised
//                 externally)
//   en       in   arbitration enable; gates only the IDLE -> BUSY transition
//   req      in   request vector; req[i] stays high while requester i needs
//                 the resource
//   gnt      out  registered one-hot grant (or zero)
//   gnt_idx  out  binary index of the granted requester; keeps its last
//                 value while gnt_vld is low
//   gnt_vld  out  high while any grant is active (equal to the OR of gnt)
//   timeout  out  one-cycle pulse when a grant is force-released
// ---------------------------------------------------------------------------
module rr_arbiter_enc4 #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      gnt_idx,
  output logic            gnt_vld,
  output logic            timeout
);

  // Elaboration-time guard. The encoded index and the rotation below are
  // written for exactly four requesters, and the hold counter is 8 bits wide.
  if (NREQ != 4) begin : g_bad_nreq
    $error("rr_arbiter_enc4: NREQ must be 4");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter_enc4: MAX_HOLD must be in 1..255");
  end

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0] state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [3:0] gnt_nxt;
  logic [1:0] idx_nxt;
  logic       vld_nxt;

  // Result of the rotating priority search.
  logic [1:0] sel;
  logic       sel_found;

  // Request line of the current owner. It is only meaningful in BUSY.
  logic       owner_req;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt, hold_nxt;
  logic       timeout_nxt;
`endif

  assign owner_req = req[gnt_idx];

  // -------------------------------------------------------------------------
  // Rotating priority search. Candidates are visited in the order ptr,
  // ptr+1, ptr+2, ptr+3. The 2-bit addition wraps modulo 4, so no explicit
  // modulo is needed. The first asserted request wins.
  // -------------------------------------------------------------------------
  always_comb begin
    logic [1:0] cand;
    // NOTE: every variable assigned in a combinational block gets a default
    // first. Any path that leaves a variable unassigned infers a latch.
    sel       = ptr;
    sel_found = 1'b0;
    cand      = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!sel_found && req[cand]) begin
        sel       = cand;
        sel_found = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. Every register defaults to holding its value. Outputs
  // are computed here and registered below, which gives the single-cycle
  // decision latency.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    idx_nxt   = gnt_idx;
    vld_nxt   = gnt_vld;
`ifdef ARB_TIMEOUT_EN
    hold_nxt    = hold_cnt;
    timeout_nxt = 1'b0;
`endif

    case (state)
      IDLE: begin
        // en gates only the start of a new grant.
        if (en && sel_found) begin
          state_nxt = BUSY;
          gnt_nxt   = 4'b0001 << sel;
          idx_nxt   = sel;
          vld_nxt   = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_nxt  = 8'd0;
`endif
        end
      end

      BUSY: begin
        // While BUSY, en and all other requests are ignored. The pointer
        // moves past the owner on any release, so an owner that re-requests
        // at once is served after the other requesters.
        if (!owner_req) begin
          state_nxt = IDLE;
          gnt_nxt   = 4'b0000;
          vld_nxt   = 1'b0;
          ptr_nxt   = gnt_idx + 2'd1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt == HOLD_LAST) begin
          state_nxt   = IDLE;
          gnt_nxt     = 4'b0000;
          vld_nxt     = 1'b0;
          ptr_nxt     = gnt_idx + 2'd1;
          timeout_nxt = 1'b1;
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
`endif
      end

      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
        vld_nxt   = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers.
  // -------------------------------------------------------------------------
  // NOTE: every register takes a value from the asynchronous reset, including
  // ptr. A reset in the middle of a grant therefore restarts arbitration from
  // requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      gnt     <= 4'b0000;
      gnt_idx <= 2'd0;
      gnt_vld <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. All
      // registers then update together from values computed in the previous
      // cycle.
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gnt     <= gnt_nxt;
      gnt_idx <= idx_nxt;
      gnt_vld <= vld_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 8'd0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= hold_nxt;
      timeout  <= timeout_nxt;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/rr_arbiter_enc4.md
Name: rr_arbiter_enc4

Overview:
- Four-requester round-robin arbiter that shares one downstream resource; the resource's select lines are driven by the encoded grant index.
- Sits between the requesting units and the shared resource.
- Issues a registered one-hot grant plus its 2-bit binary encoding.
- A grant is held until the owner drops its request. An optional timeout can force the grant off.

Parameters:
- NREQ, 4, number of requesters. Fixed at 4; the encoded index width is 2. Any other value is unsupported.
- MAX_HOLD, 16, maximum cycles one grant may be held. Used only when ARB_TIMEOUT_EN is defined. Legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset; deassertion is synchronised externally
- en  input  1  arbitration enable; when low, no new grant is issued
- req  input  4  request vector; req[i] held high while requester i needs the resource
- gnt  output  4  one-hot grant, registered
- gnt_idx  output  2  binary index of the granted requester (e.g. gnt=4'b0100 gives gnt_idx=2'd2); holds last value when gnt_vld=0
- gnt_vld  output  1  high while any grant is active
- timeout  output  1  one-cycle pulse when a grant is force-released; tied 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (rst_n low, async): gnt=0, gnt_idx=0, gnt_vld=0, timeout=0, state=IDLE, ptr=0, hold_cnt=0.
- State machine has two states, IDLE and BUSY.
- IDLE:
  - If en=1 and req!=0, select the first set req bit searching ptr, ptr+1, ..., ptr+3 (mod 4).
  - Next cycle: gnt=onehot(sel), gnt_idx=sel, gnt_vld=1, state goes to BUSY, hold_cnt=0.
  - Otherwise remain in IDLE.
- Latency: req asserted at edge t gives the grant visible after edge t+1. There is a single-cycle registered decision.
- BUSY:
  - If req[gnt_idx]=0, release on the next edge: gnt=0, gnt_vld=0, ptr=(gnt_idx+1) mod 4, go to IDLE.
  - Requests from other requesters, and en, are ignored while BUSY.
- After a release there is at least one IDLE cycle before the next grant. Back-to-back grants are therefore spaced by two cycles.
- Pointer wrap-around: a grant to 3 sets ptr=0.
- Simultaneous requests: resolved purely by ptr order. This is starvation-free; each requester waits at most 3 grants.
- en deasserted mid-grant: the grant continues until released; en only gates the IDLE to BUSY transition.
- Owner drops then re-raises req in the same cycle as release: treated as a new request. It competes in IDLE with ptr already advanced past it.
- Reset mid-grant: immediate return to reset values; ptr is not preserved.
- gnt is always one-hot or zero; gnt_vld equals the OR of gnt.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt (8 bits) increments each BUSY cycle.
  - When hold_cnt reaches MAX_HOLD-1 with req[gnt_idx] still high, release on the next edge exactly as a normal release: ptr advances, go to IDLE.
  - timeout pulses high for that one cycle, coincident with gnt dropping.
  - A timed-out requester still holding req is re-arbitrated fairly after the others.
- Undefined: no counter; grants are held indefinitely; timeout is tied 0.

Test Plan:
- Reset, then req=4'b0001, en=1 -> gnt=4'b0001, gnt_idx=0, gnt_vld=1 one cycle later. Drop req -> gnt=0 next cycle, ptr=1.
- req=4'b1111 held, each owner drops for one cycle after 3 cycles of grant -> grant order 0,1,2,3,0, with one IDLE cycle between grants.
- ptr=3 with req=4'b1001 -> grant to 3 (gnt_idx=3). After release, ptr=0 and the next grant goes to 0.
- en=0 with req=4'b0100 -> gnt stays 0 for 5 cycles. Raise en -> gnt=4'b0100, gnt_idx=2 one cycle later. Lower en while BUSY -> grant held.
- Assert rst_n=0 mid-grant (gnt=4'b0010) -> all outputs 0 immediately. After reset, req=4'b0010 is granted from ptr=0 with gnt_idx=1.
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=4'b0011 held -> grant 0 for 4 cycles, then timeout=1 for one cycle, then grant 1 after one IDLE cycle. Without the macro, grant 0 is held for 50 cycles and timeout stays 0.
